// File: rtl/regdata_sel_pipe.sv
// rtl/regdata_sel_pipe.sv - write-back data selector fused with the MEM/WB register chain
//
// Purpose:
//   Picks one of NSRC candidate results using a binary select. Tags the result
//   with a destination register and a write enable. Carries it through DEPTH
//   register stages to the GRF write port. Supports stall (hold all stages),
//   flush (empty all stages), and a sticky out-of-range select flag.
//
// Optional feature macro: WB_ZERO_GUARD_EN
//   When defined, a write to register $0 is dropped at capture time.
//
// Ports:
//   clk       in   1            rising-edge clock
//   reset     in   1            synchronous, active-low reset
//   src_data  in   NSRC*WIDTH   packed sources; source i at [i*WIDTH +: WIDTH]
//   sel       in   SELW         binary source index
//   a3        in   5            destination register
//   we        in   1            register write request
//   valid_in  in   1            input slot carries a real instruction
//   stall     in   1            hold every stage
//   flush     in   1            kill every stage (wins over stall)
//   wb_data   out  WIDTH        last-stage data
//   wb_a3     out  5            last-stage destination
//   wb_we     out  1            last-stage valid & we
//   valid_out out  1            last stage holds a real instruction
//   sel_err   out  1            sticky: out-of-range select was accepted
module regdata_sel_pipe #(
  parameter int               WIDTH    = 32,
  parameter int               NSRC     = 4,
  parameter int               DEPTH    = 1,
  parameter logic [WIDTH-1:0] ERR_FILL = '1,
  localparam int              SELW     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel,
  input  logic [4:0]            a3,
  input  logic                  we,
  input  logic                  valid_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WIDTH-1:0]      wb_data,
  output logic [4:0]            wb_a3,
  output logic                  wb_we,
  output logic                  valid_out,
  output logic                  sel_err
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_we;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [4:0]       r_a3   [DEPTH];
  logic             r_sel_err;

  logic [31:0]      w_sel_idx;
  logic             w_sel_ok;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_we_in;

  // Widen the select so the range test also works when NSRC is not a power of two.
  assign w_sel_idx = 32'(sel);
  assign w_sel_ok  = (w_sel_idx < 32'(NSRC));

  always_comb begin
    w_sel_data = ERR_FILL;
    for (int i = 0; i < NSRC; i++) begin
      if (w_sel_idx == 32'(i)) begin
        w_sel_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef WB_ZERO_GUARD_EN
  assign w_we_in = we & (a3 != 5'd0);
`else
  assign w_we_in = we;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid   <= '0;
      r_we      <= '0;
      r_sel_err <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
        r_a3[k]   <= '0;
      end
    end else if (flush) begin
      // Data and a3 are cleared as well, so a bubble never shows stale values.
      r_valid <= '0;
      r_we    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
        r_a3[k]   <= '0;
      end
    end else if (!stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_we[k]    <= r_we[k-1];
        r_data[k]  <= r_data[k-1];
        r_a3[k]    <= r_a3[k-1];
      end
      r_valid[0] <= valid_in;
      r_we[0]    <= w_we_in;
      r_data[0]  <= w_sel_data;
      r_a3[0]    <= a3;
      if (valid_in && !w_sel_ok) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  assign wb_data   = r_data[DEPTH-1];
  assign wb_a3     = r_a3[DEPTH-1];
  assign wb_we     = r_valid[DEPTH-1] & r_we[DEPTH-1];
  assign valid_out = r_valid[DEPTH-1];
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_regdata_sel_pipe.sv
// tb/tb_regdata_sel_pipe.sv - scoreboard bench for regdata_sel_pipe (NSRC=3, DEPTH=2)
module tb_regdata_sel_pipe;

  localparam int W     = 32;
  localparam int NSRC  = 3;
  localparam int DEPTH = 2;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [4:0]  a3;
    logic        we;
  } entry_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  a3;
    logic        we;
    logic        valid;
    logic        err;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [3*W-1:0]  src_data;
  logic [1:0]      sel;
  logic [4:0]      a3;
  logic            we;
  logic            valid_in;
  logic            stall;
  logic            flush;
  logic [W-1:0]    wb_data;
  logic [4:0]      wb_a3;
  logic            wb_we;
  logic            valid_out;
  logic            sel_err;

  regdata_sel_pipe #(.WIDTH(W), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .sel(sel), .a3(a3),
    .we(we), .valid_in(valid_in), .stall(stall), .flush(flush),
    .wb_data(wb_data), .wb_a3(wb_a3), .wb_we(wb_we),
    .valid_out(valid_out), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the pipe is a queue of DEPTH slots, with the newest entry at the front.
  entry_t pipe[$];
  logic   m_err;
  exp_t   exp_q[$];

  task automatic clear_pipe();
    entry_t z;
    z.valid = 1'b0; z.data = '0; z.a3 = '0; z.we = 1'b0;
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: present inputs, take the edge, advance the model, queue the expected outputs.
  task automatic cycle(input logic rst, input logic fl, input logic st, input logic vi,
                       input logic [1:0] s, input logic [4:0] a, input logic w,
                       input logic [3*W-1:0] src);
    entry_t e;
    exp_t   x;
    reset = rst; flush = fl; stall = st; valid_in = vi;
    sel = s; a3 = a; we = w; src_data = src;
    @(posedge clk);
    if (!rst) begin
      clear_pipe();
      m_err = 1'b0;
    end else if (fl) begin
      clear_pipe();
    end else if (!st) begin
      e.valid = vi;
      e.data  = (int'(s) < NSRC) ? src[int'(s)*W +: W] : 32'hffffffff;
      e.a3    = a;
`ifdef WB_ZERO_GUARD_EN
      e.we    = w && (a != 5'd0);
`else
      e.we    = w;
`endif
      pipe.push_front(e);
      void'(pipe.pop_back());
      if (vi && int'(s) >= NSRC) m_err = 1'b1;
    end
    x.data  = pipe[DEPTH-1].data;
    x.a3    = pipe[DEPTH-1].a3;
    x.we    = pipe[DEPTH-1].valid & pipe[DEPTH-1].we;
    x.valid = pipe[DEPTH-1].valid;
    x.err   = m_err;
    exp_q.push_back(x);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, '0);
  endtask

  // Monitor: the DUT presents its registered outputs after every edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("wb_data",   wb_data,          x.data);
      chk("wb_a3",     32'(wb_a3),       32'(x.a3));
      chk("wb_we",     32'(wb_we),       32'(x.we));
      chk("valid_out", 32'(valid_out),   32'(x.valid));
      chk("sel_err",   32'(sel_err),     32'(x.err));
    end
  end

  localparam logic [31:0] VA = 32'hAAAA_0001;
  localparam logic [31:0] VB = 32'hBBBB_0002;
  localparam logic [31:0] VC = 32'hCCCC_0003;

  initial begin
    logic [3*W-1:0] abc;
    logic [3*W-1:0] rnd;
    abc = {VC, VB, VA};
    m_err = 1'b0;
    clear_pipe();

    // Reset, then pass-through of source 1 to a3=5.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, abc);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, abc);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 5'd5, 1'b1, abc);
    idle(2);

    // Out-of-range select, then valid traffic that must not clear the sticky flag.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 5'd7, 1'b1, abc);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 5'd8, 1'b1, abc);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 5'd9, 1'b0, abc);
    idle(2);

    // Stall for three cycles; inputs offered during the stall are discarded.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 5'd12, 1'b1, abc);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 5'd13, 1'b1, abc);
    idle(3);

    // Flush together with stall and valid_in while two entries are in flight.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 5'd1, 1'b1, abc);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 5'd2, 1'b1, abc);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 5'd3, 1'b1, abc);
    idle(2);

    // Write to $0.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 5'd0, 1'b1, abc);
    idle(2);

    // Randomised traffic, including occasional mid-flight resets.
    for (int i = 0; i < 500; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      cycle(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)),
            rnd);
    end
    idle(1);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regdata_sel_pipe.md
# regdata_sel_pipe

Parametrised write-back data selector fused with the MEM/WB pipeline register chain of the pipelined MIPS core. Each cycle it picks one of `NSRC` candidate results by a binary select, tags it with destination register and write enable, and carries it through `DEPTH` register stages to the GRF write port. It supports pipeline stall (hold) and flush (bubble insertion), and flags out-of-range selects with a sticky error bit.

## Interface

Parameters:
- `WIDTH`, 32: data width of every source and of `wb_data`.
- `NSRC`, 4: number of candidate sources (2..8). Typical order: ALU result, DM read data, PC+8, HI/LO.
- `DEPTH`, 1: number of register stages between input and output (1..4).
- `ERR_FILL`, all ones (`32'hffffffff` at default width): data value substituted for an out-of-range select.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `src_data`, in, `NSRC*WIDTH`: packed sources; source i occupies `[i*WIDTH +: WIDTH]`.
- `sel`, in, `SELW` = max(1, clog2(`NSRC`)): binary index of the chosen source.
- `a3`, in, 5: destination register number.
- `we`, in, 1: register write request.
- `valid_in`, in, 1: the input slot carries a real instruction.
- `stall`, in, 1: hold every stage.
- `flush`, in, 1: kill every stage.
- `wb_data`, out, `WIDTH`: selected data at the last stage.
- `wb_a3`, out, 5: destination at the last stage.
- `wb_we`, out, 1: qualified write enable (last-stage valid AND last-stage we).
- `valid_out`, out, 1: last stage holds a real instruction.
- `sel_err`, out, 1: sticky; an out-of-range select was accepted.

## Operation

- Selection is combinational at the input. `sel` < `NSRC` yields source `sel`. Otherwise the result is `ERR_FILL`.
- Each stage k holds {valid, data, a3, we}. Stage 0 loads from the input. Stage k loads from stage k-1.
- The priority order on every edge is reset, then flush, then stall, then shift.
  - `reset` = 0: every stage valid, we, a3 and data clear to 0. `sel_err` clears to 0.
  - `flush` = 1: every stage valid and we clear to 0. Data and a3 are don't-care but are cleared to 0. The input slot is discarded even if `valid_in` = 1.
  - `stall` = 1 with `flush` = 0: all stages hold. The input is not accepted.
  - Otherwise all stages shift by one, and stage 0 loads {`valid_in`, selected data, `a3`, `we`}.
- `sel_err` sets when an input is accepted (shift case) with `valid_in` = 1 and `sel` ≥ `NSRC`. Only `reset` clears it.
- Outputs come straight from the last stage's registers. `wb_we` = valid & we. There is no combinational path from input to output.

## Timing

- Latency is exactly `DEPTH` unstalled edges from acceptance to appearance at the outputs.
- Each stall cycle adds one cycle of latency and leaves the outputs unchanged.
- Throughput is one input per unstalled cycle.
- After reset is released, all outputs read 0. The first acceptance is possible on the first edge with `reset` = 1.
- Reset asserted mid-flight: in-flight entries are lost on that edge, with no partial write.
- `flush` and `stall` in the same cycle: flush wins, and all stages are empty after the edge.
- Invalid entries still shift normally. This gives bubble propagation.

## Configuration

- `WB_ZERO_GUARD_EN`
  - Defined: stage 0 captures we = `we` & (`a3` != 0). A write to $0 never reaches `wb_we`. Data and a3 are still captured.
  - Undefined: `we` passes through unchanged. The GRF is responsible for ignoring $0.

## Test plan

All scenarios use `NSRC`=3, `DEPTH`=2, `WIDTH`=32.

- Reset then pass-through. Hold `reset`=0 for 2 cycles, then apply `src_data`={C,B,A}, `sel`=1, `a3`=5, `we`=1, `valid_in`=1. Required: outputs are all 0 during reset. Exactly 2 edges after acceptance, `wb_data`=B, `wb_a3`=5, `wb_we`=1, `valid_out`=1.
- Out-of-range select. Apply `sel`=3 with `valid_in`=1. Required: after 2 edges, `wb_data`=`32'hffffffff`. `sel_err`=1 one edge after acceptance and remains 1 through later valid traffic until reset.
- Stall. Accept X, then hold `stall`=1 for 3 cycles. Required: X reaches the output 5 edges after acceptance. Inputs presented during the stall are not captured.
- Flush priority. With two valid entries in flight, assert `flush`=1 and `stall`=1 together with `valid_in`=1. Required: next cycle `valid_out`=0 and `wb_we`=0, and on the following cycle both remain 0.
- $0 guard. Apply `a3`=0, `we`=1, `valid_in`=1. Required: with `WB_ZERO_GUARD_EN` defined, `wb_we`=0 when the entry reaches the output. Without the macro, `wb_we`=1.
